// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer for the SM83 8-bit accumulator ALU group, owning A and F.
// Define ALU_ISSUE_IMM_EN to support the 11ooo110 immediate forms; otherwise they retire as illegal.
module alu_issue_ctrl #(
  parameter logic [7:0] A_RESET = 8'h01,
  parameter logic [7:0] F_RESET = 8'hB0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_byte,
  output logic       instr_ready,
  output logic [2:0] reg_sel,
  input  logic [7:0] reg_rdata,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [7:0] alu_res,
  input  logic [7:0] alu_flags,
  output logic [7:0] reg_a,
  output logic [7:0] reg_f,
  output logic       done,
  output logic       illegal
);
  localparam logic [1:0] IDLE = 2'd0, IMM = 2'd1, MEM = 2'd2, EXEC = 2'd3;
  logic [1:0] state_q, state_d;
  logic [7:0] op_q, op_d, opb_q, opb_d, a_q, a_d, f_q, f_d, alu_a_q, alu_b_q;
  logic [3:0] alu_op_q, op_map;
  logic       done_q, done_d, illegal_q, illegal_d, exec, is_imm, unused_flags;
  assign exec = state_q == EXEC;
  assign unused_flags = ^alu_flags[3:0];
`ifdef ALU_ISSUE_IMM_EN
  assign is_imm = instr_byte[7:6] == 2'b11 && instr_byte[2:0] == 3'd6;
`else
  assign is_imm = 1'b0;
`endif
  always_comb begin
    case (op_q[5:3])
      3'd4:    op_map = 4'd5;
      3'd5:    op_map = 4'd7;
      3'd7:    op_map = 4'd4;
      default: op_map = {1'b0, op_q[5:3]};
    endcase
  end
  // Only the register form reaches EXEC with rrr != 6; (HL) and immediate use the latched byte.
  assign alu_a       = exec ? a_q : alu_a_q;
  assign alu_b       = exec ? (op_q[2:0] != 3'd6 ? reg_rdata : opb_q) : alu_b_q;
  assign alu_op      = exec ? op_map : alu_op_q;
  assign alu_cin     = f_q[4];
  assign instr_ready = state_q == IDLE || state_q == IMM;
  assign mem_req     = state_q == MEM;
  assign reg_sel     = op_q[2:0];
  assign reg_a       = a_q;
  assign reg_f       = f_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opb_d     = opb_q;
    a_d       = a_q;
    f_d       = f_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: if (instr_valid) begin
        op_d      = instr_byte;
        state_d   = instr_byte[7:6] == 2'b10 ? (instr_byte[2:0] == 3'd6 ? MEM : EXEC) : is_imm ? IMM : IDLE;
        illegal_d = instr_byte[7:6] != 2'b10 && !is_imm;
      end
      IMM: if (instr_valid) begin
        opb_d   = instr_byte;
        state_d = EXEC;
      end
      MEM: if (mem_ack) begin
        opb_d   = mem_rdata;
        state_d = EXEC;
      end
      default: begin
        a_d     = op_q[5:3] == 3'd7 ? a_q : alu_res;
        f_d     = {alu_flags[7:4], 4'b0};
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 8'h00;
      opb_q     <= 8'h00;
      a_q       <= A_RESET;
      f_q       <= {F_RESET[7:4], 4'b0};
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opb_q     <= opb_d;
      a_q       <= a_d;
      f_q       <= f_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (exec) begin
        alu_a_q  <= alu_a;
        alu_b_q  <= alu_b;
        alu_op_q <= alu_op;
      end
    end
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/writeback sequencer that drives `alu8` for the SM83 8-bit accumulator ALU group: `0x80`–`0xBF` and the immediate forms `11xxx110`. It accepts opcode bytes from the fetch unit and gathers operand B from the register file, the (HL) memory port, or an immediate byte. It drives `alu8` and writes the result and flags back into the A and F registers, which this block owns. It sits between fetch/decode and `alu8` in the CPU core.

## Interface
- `A_RESET`, default 8'h01: reset value of A.
- `F_RESET`, default 8'hB0: reset value of F; bits [3:0] are ignored and forced to 0.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `instr_valid` input 1: fetch byte valid.
- `instr_byte` input 8: opcode or immediate byte.
- `instr_ready` output 1: block accepts a byte this cycle.
- `reg_sel` output 3: register-file read index; uses opcode bits [2:0] (0=B … 5=L, 7=A).
- `reg_rdata` input 8: combinational register-file read data for `reg_sel`.
- `mem_req` output 1: (HL) read request, level, held until ack.
- `mem_ack` input 1: read data valid.
- `mem_rdata` input 8: read data.
- `alu_a`, `alu_b` output 8: ALU operands.
- `alu_op` output 4: ALU opcode (ADD=0, ADC=1, SUB=2, SBC=3, CP=4, AND=5, OR=6, XOR=7).
- `alu_cin` output 1: equals F[4].
- `alu_res` input 8: ALU result.
- `alu_flags` input 8: ALU flags.
- `reg_a`, `reg_f` output 8: architectural A and F.
- `done` output 1: one-cycle pulse when an instruction retires.
- `illegal` output 1: one-cycle pulse when a non-ALU opcode is accepted.

## Operation
- **States:** IDLE, IMM, MEM, EXEC.
- **IDLE:** `instr_ready`=1. On `instr_valid`, latch the opcode and decode it:
  - `10ooo rrr` with rrr≠6 → EXEC.
  - rrr=6 → MEM.
  - `11ooo110` → IMM.
  - Anything else → `illegal` pulse next cycle, stay in IDLE.
- **IMM:** `instr_ready`=1. The next valid byte is latched as operand B → EXEC.
- **MEM:** `mem_req`=1 until the cycle `mem_ack`=1. Latch `mem_rdata` that cycle → EXEC. An ack in the first MEM cycle is legal.
- **Operation map (opcode bits [5:3]):** 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP. Remap to `alu_op`.
- **EXEC:** one cycle.
  - `alu_a`=A.
  - `alu_b` is `reg_rdata` (register form; rrr=7 reads A) or the latched byte.
  - At the clock edge, F←{`alu_flags[7:4]`,4'b0}; A←`alu_res` except for CP, which leaves A unchanged. → IDLE.
- **Outside EXEC:** `alu_op`/`alu_a`/`alu_b` hold their last values. Nothing consumes them.
- `reg_sel` is driven from the latched opcode in all states.
- **Reset values:**
  - IDLE state.
  - A=`A_RESET`, F={`F_RESET[7:4]`,4'b0}.
  - `mem_req`, `done`, `illegal` = 0.
  - `alu_a`/`alu_b` = 0, `alu_op` = 0.
- **Reset mid-operation:** any pending instruction is discarded with no writeback, and `mem_req` drops immediately (asynchronous).
- `mem_ack` outside MEM is ignored. `instr_valid` in MEM/EXEC is not accepted (`instr_ready`=0).

## Timing
- **Register form:** opcode accepted at cycle T → EXEC at T+1 → new A/F and `done`=1 at T+2.
- **Immediate form:** opcode at T, immediate at T+k (k≥1) → EXEC at T+k+1 → `done` at T+k+2.
- **(HL) form:** ack at cycle M → EXEC at M+1 → `done` at M+2.
- `illegal` is asserted at T+1 for an opcode accepted at T.
- The next opcode can be accepted in the same cycle `done` or `illegal` is high (the block is back in IDLE). Throughput for register ops is one instruction per 2 cycles.
- `done` and `illegal` are registered, never both high, and high for exactly one cycle.

## Configuration
- `ALU_ISSUE_IMM_EN` defined: the immediate forms `11ooo110` are supported and the IMM state exists.
- Not defined: those opcodes take the illegal path (`illegal` pulse, A/F unchanged), and IMM is unreachable/removed.

## Test plan
- **ADD B.** A=0x3A, B=0xC6, byte 0x80 → A=0x00, F=0xB0, `done` at T+2.
- **ADC E with carry.** A=0xE1, F=0x10, E=0x0F, byte 0x8B → `alu_cin`=1 in EXEC, A=0xF1, F=0x20.
- **CP immediate** (macro defined). A=0x3C, bytes 0xFE then 0x2F with 2 idle cycles between → A=0x3C, F=0x60, `done` 2 cycles after the immediate.
- **AND (HL).** A=0xF0, byte 0xA6, `mem_ack` with `mem_rdata`=0x0F after 3 cycles of `mem_req` → A=0x00, F=0xA0, and `mem_req` deasserted the cycle after ack.
- **Illegal opcodes.**
  - Byte 0x00 → `illegal` pulse at T+1, A/F unchanged.
  - Without `ALU_ISSUE_IMM_EN`, byte 0xC6 → `illegal`, the following byte is treated as a new opcode.
- **Reset mid-operation.** Assert `rst` while in MEM → `mem_req`=0 asynchronously, A=0x01, F=0xB0. A late `mem_ack` after release has no effect.
